// File: rtl/score_board_pkg.sv
// Shared types, colours and BCD helpers for the score overlay.
// Imported by score_board and score_font_rom.
package score_board_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [4:0] bcd_score_t;

    typedef enum logic [1:0] {
        FIELD_NONE,
        FIELD_SCORE,
        FIELD_HISCORE
    } field_t;

    localparam logic [11:0] SCORE_COLOR   = 12'hFFF;
    localparam logic [11:0] HISCORE_COLOR = 12'hFF0;
    localparam bcd_score_t  SCORE_MAX     = 20'h99999;

    // Per-digit decimal add; a carry out of the top digit clamps to SCORE_MAX.
    function automatic bcd_score_t bcd_add(input bcd_score_t a, input bcd_score_t b);
        bcd_score_t sum;
        logic [4:0] d;
        logic       c;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = {1'b0, a[i]} + {1'b0, b[i]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum[i] = d[3:0];
        end
        return c ? SCORE_MAX : sum;
    endfunction

    function automatic bcd_score_t to_bcd(input int value);
        bcd_score_t r;
        int         v;
        r = '0;
        v = value;
        if (v > 99999) return SCORE_MAX;
        for (int i = 0; i < 5; i++) begin
            r[i] = 4'(v % 10);
            v    = v / 10;
        end
        return r;
    endfunction

    // Digit idx 0 is the most significant; only the last digit is never blanked.
    function automatic logic lead_blank(input bcd_score_t v, input logic [2:0] idx);
        logic blank;
        blank = (idx != 3'd4);
        for (int p = 0; p < 5; p++) begin
            if (p >= 4 - int'(idx) && v[p] != 4'd0) blank = 1'b0;
        end
        return blank;
    endfunction

endpackage

// File: rtl/score_board_font_rom.sv
// 10-glyph 8x8 digit font with a registered row output (one clock of latency).
module score_font_rom
    import score_board_pkg::*;
(
    input  logic       vga_pix_clk,
    input  bcd_digit_t digit,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    logic [63:0] glyph;

    // Row 0 is the top byte of each 64-bit glyph; bit 7 is the leftmost pixel.
    always_comb begin
        glyph = 64'h0;
        case (digit)
            4'd0: glyph = 64'h3C666E7666663C00;
            4'd1: glyph = 64'h1838181818187E00;
            4'd2: glyph = 64'h3C66060C30607E00;
            4'd3: glyph = 64'h3C66061C06663C00;
            4'd4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'd5: glyph = 64'h7E607C0606663C00;
            4'd6: glyph = 64'h3C607C6666663C00;
            4'd7: glyph = 64'h7E060C1830303000;
            4'd8: glyph = 64'h3C66663C66663C00;
            4'd9: glyph = 64'h3C66663E060C3800;
            default: glyph = 64'h0;
        endcase
    end

    always_ff @(posedge vga_pix_clk) begin
        bits <= glyph[{3'(3'd7 - row), 3'b000} +: 8];
    end

endmodule

// File: rtl/score_board.sv
// BCD score counter with a per-frame latched display and a tile-based overlay.
// Define SCORE_BOARD_HISCORE_EN to add the high-score register and its field.
module score_board
    import score_board_pkg::*;
#(
    parameter int CANDY_POINTS   = 10,
    parameter int COOKIE_POINTS  = 50,
    parameter int SCORE_TILE_X   = 1,
    parameter int HISCORE_TILE_X = 11,
    parameter int SCORE_TILE_Y   = 1
) (
    input  logic        vga_pix_clk,
    input  logic        rst,
    input  logic        frame_stb,
    input  logic        ate_candy_stb,
    input  logic        ate_power_cookie_stb,
    input  logic [7:0]  sx,
    input  logic [8:0]  sy,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic [19:0] score_bcd
);

    localparam bcd_score_t CANDY_BCD  = to_bcd(CANDY_POINTS);
    localparam bcd_score_t COOKIE_BCD = to_bcd(COOKIE_POINTS);
    localparam bcd_score_t BOTH_BCD   = to_bcd(CANDY_POINTS + COOKIE_POINTS);

    bcd_score_t score;
    bcd_score_t display_score;
    bcd_score_t add_amt;

    always_comb begin
        add_amt = '0;
        case ({ate_power_cookie_stb, ate_candy_stb})
            2'b01:   add_amt = CANDY_BCD;
            2'b10:   add_amt = COOKIE_BCD;
            2'b11:   add_amt = BOTH_BCD;
            default: add_amt = '0;
        endcase
    end

`ifdef SCORE_BOARD_HISCORE_EN
    bcd_score_t hiscore;
`endif

    // display_score takes the pre-update score, so a strobe on the frame edge shows next frame.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            score         <= '0;
            display_score <= '0;
`ifdef SCORE_BOARD_HISCORE_EN
            hiscore       <= '0;
`endif
        end else begin
            if (ate_candy_stb || ate_power_cookie_stb) score <= bcd_add(score, add_amt);
            if (frame_stb) display_score <= score;
`ifdef SCORE_BOARD_HISCORE_EN
            if (frame_stb && (display_score > hiscore)) hiscore <= display_score;
`endif
        end
    end

    assign score_bcd = score;

    logic [4:0] tile_x;
    logic [5:0] tile_y;
    logic       on_row;
    logic       in_score;
    logic [2:0] score_idx;

    assign tile_x    = sx[7:3];
    assign tile_y    = sy[8:3];
    assign on_row    = (int'(tile_y) == SCORE_TILE_Y);
    assign in_score  = on_row && (int'(tile_x) >= SCORE_TILE_X) && (int'(tile_x) < SCORE_TILE_X + 5);
    assign score_idx = 3'(int'(tile_x) - SCORE_TILE_X);

`ifdef SCORE_BOARD_HISCORE_EN
    logic       in_hi;
    logic [2:0] hi_idx;
    assign in_hi  = on_row && (int'(tile_x) >= HISCORE_TILE_X) && (int'(tile_x) < HISCORE_TILE_X + 5);
    assign hi_idx = 3'(int'(tile_x) - HISCORE_TILE_X);
`endif

    field_t     field;
    bcd_digit_t digit;
    logic       blank;

    always_comb begin
        field = FIELD_NONE;
        digit = '0;
        blank = 1'b0;
        if (in_score) begin
            field = FIELD_SCORE;
            digit = display_score[3'd4 - score_idx];
            blank = lead_blank(display_score, score_idx);
        end
`ifdef SCORE_BOARD_HISCORE_EN
        else if (in_hi) begin
            field = FIELD_HISCORE;
            digit = hiscore[3'd4 - hi_idx];
            blank = lead_blank(hiscore, hi_idx);
        end
`endif
    end

    // Field, blank and column ride alongside the ROM's one-cycle read.
    field_t     field_q;
    logic       blank_q;
    logic [2:0] col_q;
    logic [7:0] glyph_row;

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            field_q <= FIELD_NONE;
            blank_q <= 1'b0;
            col_q   <= '0;
        end else begin
            field_q <= field;
            blank_q <= blank;
            col_q   <= sx[2:0];
        end
    end

    score_font_rom u_font (
        .vga_pix_clk (vga_pix_clk),
        .digit       (digit),
        .row         (sy[2:0]),
        .bits        (glyph_row)
    );

    logic        pixel_on;
    logic [11:0] color;

    assign pixel_on    = (field_q != FIELD_NONE) && !blank_q && glyph_row[3'd7 - col_q];
    assign color       = (field_q == FIELD_HISCORE) ? HISCORE_COLOR : SCORE_COLOR;
    assign {R, G, B}   = pixel_on ? color : 12'h000;

endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board: scoring, saturation, frame latching and glyph rendering.
// Build with SCORE_BOARD_HISCORE_EN defined to exercise the high-score field.
module tb_score_board;

    logic        vga_pix_clk = 1'b0;
    logic        rst;
    logic        frame_stb;
    logic        ate_candy_stb;
    logic        ate_power_cookie_stb;
    logic [7:0]  sx;
    logic [8:0]  sy;
    logic [3:0]  R, G, B;
    logic [19:0] score_bcd;

    int errors = 0;
    int checks = 0;

    score_board dut (
        .vga_pix_clk          (vga_pix_clk),
        .rst                  (rst),
        .frame_stb            (frame_stb),
        .ate_candy_stb        (ate_candy_stb),
        .ate_power_cookie_stb (ate_power_cookie_stb),
        .sx                   (sx),
        .sy                   (sy),
        .R                    (R),
        .G                    (G),
        .B                    (B),
        .score_bcd            (score_bcd)
    );

    always #5 vga_pix_clk = ~vga_pix_clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge vga_pix_clk);
        #1;
    endtask

    task automatic check_score(input string tag, input logic [19:0] exp);
        checks++;
        assert (score_bcd === exp) else begin
            errors++;
            $error("FAIL %s: score_bcd=%h expected %h", tag, score_bcd, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [11:0] exp);
        checks++;
        assert ({R, G, B} === exp) else begin
            errors++;
            $error("FAIL %s: rgb=%h expected %h", tag, {R, G, B}, exp);
        end
    endtask

    task automatic strobe(input logic candy, input logic cookie);
        ate_candy_stb        = candy;
        ate_power_cookie_stb = cookie;
        tick();
        ate_candy_stb        = 1'b0;
        ate_power_cookie_stb = 1'b0;
    endtask

    task automatic frame();
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
    endtask

    task automatic pixel(input int x, input int y, input logic [11:0] exp);
        sx = x[7:0];
        sy = y[8:0];
        tick();
        check_rgb($sformatf("pix_%0d_%0d", x, y), exp);
    endtask

    initial begin
        logic [7:0] glyph_byte;

        rst = 1'b1; frame_stb = 1'b0; ate_candy_stb = 1'b0; ate_power_cookie_stb = 1'b0;
        sx = '0; sy = '0;

        // Reset wins over a simultaneous strobe.
        ate_candy_stb = 1'b1;
        tick();
        check_score("rst_override", 20'h00000);
        check_rgb("rst_rgb", 12'h000);

        // Strobe in the first cycle after reset deasserts is counted.
        rst = 1'b0;
        tick();
        ate_candy_stb = 1'b0;
        check_score("post_rst_strobe", 20'h00010);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        check_score("three_candy", 20'h00030);

        strobe(1'b1, 1'b0);
        check_score("four_candy", 20'h00040);
        strobe(1'b1, 1'b1);
        check_score("both_strobes", 20'h00100);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        check_score("reach_120", 20'h00120);

        // Frame edge with a coinciding strobe: display gets 00120, score goes to 00130.
        frame_stb = 1'b1; ate_candy_stb = 1'b1;
        tick();
        frame_stb = 1'b0; ate_candy_stb = 1'b0;
        check_score("frame_coincide", 20'h00130);

        // Tiles 1 and 2 are leading zeros of 00120 and stay blank.
        for (int y = 8; y < 16; y++)
            for (int x = 8; x < 24; x++)
                pixel(x, y, 12'h000);

        // Tile 3 holds '1': rows 0 and 6.
        glyph_byte = 8'h18;
        for (int c = 0; c < 8; c++) pixel(24 + c, 8, glyph_byte[7 - c] ? 12'hFFF : 12'h000);
        glyph_byte = 8'h7E;
        for (int c = 0; c < 8; c++) pixel(24 + c, 14, glyph_byte[7 - c] ? 12'hFFF : 12'h000);

        // Least significant '0' always drawn, row 1 = 0x66.
        pixel(41, 9, 12'hFFF);
        pixel(40, 9, 12'h000);

        // Outside the field.
        pixel(48, 8, 12'h000);
        pixel(27, 0, 12'h000);
        pixel(27, 16, 12'h000);

        // Exactly one cycle of RGB latency.
        pixel(24, 8, 12'h000);
        sx = 8'd27;
        #1;
        check_rgb("latency_hold", 12'h000);
        tick();
        check_rgb("latency_one", 12'hFFF);

        // Score is 00130 but the display keeps 00120 ('2' row 3 col 3 is off) until frame_stb.
        pixel(35, 11, 12'h000);
        pixel(35, 11, 12'h000);
        frame();
        pixel(35, 11, 12'hFFF);

        // Saturation: 130 + 1997*50 + 10 = 99990.
        for (int i = 0; i < 1997; i++) strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
        check_score("preload_99990", 20'h99990);
        strobe(1'b0, 1'b1);
        check_score("sat_cookie", 20'h99999);
        strobe(1'b1, 1'b0);
        check_score("sat_candy", 20'h99999);
        strobe(1'b1, 1'b1);
        check_score("sat_both", 20'h99999);

`ifdef SCORE_BOARD_HISCORE_EN
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) strobe(1'b0, 1'b1);
        check_score("hi_reach_500", 20'h00500);
        frame();
        frame();
        // Tile 13 shows '5': row 0 col 1 on, row 3 col 3 off.
        pixel(105, 8, 12'hFF0);
        pixel(107, 11, 12'h000);
        rst = 1'b1; tick(); rst = 1'b0;
        check_score("hi_rst_score", 20'h00000);
        pixel(105, 8, 12'h000);
        pixel(107, 11, 12'h000);
        pixel(121, 9, 12'hFF0);
        pixel(41, 9, 12'hFFF);
        for (int i = 0; i < 6; i++) strobe(1'b0, 1'b1);
        check_score("hi_reach_300", 20'h00300);
        frame();
        frame();
        // Tile 13 shows '3': row 3 col 3 on, row 0 col 1 off.
        pixel(107, 11, 12'hFF0);
        pixel(105, 8, 12'h000);
`else
        rst = 1'b1; tick(); rst = 1'b0;
        check_score("rst_again", 20'h00000);
        pixel(41, 9, 12'hFFF);
        pixel(121, 9, 12'h000);
        pixel(107, 11, 12'h000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
